mod_reg16_16to1: RTL and testbench
==================================

Name: mod_reg16_16to1

Overview:
- Block-to-byte serializer; the inverse of the 16-byte collector that assembles AES blocks from a byte stream.
- Accepts one 128-bit AES state/ciphertext block in a single cycle through a valid/ready handshake.
- Emits the block as 16 bytes, byte index 0 first, over a valid/ready byte stream.
- Sits between the AES core output and the byte-wide host/output interface.

Parameters:
- N, 16, number of bytes per block; counter width is $clog2(N).
- W, 8, bits per byte/output lane.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- i  input  N x W (packed [(N-1):0][7:0], 128 bits)  block to serialize; byte i[0] is sent first
- in_valid  input  1  block on i is valid
- in_ready  output  1  block will be captured this cycle if in_valid=1
- o  output  W  current output byte
- o_valid  output  1  byte on o is valid
- o_ready  input  1  downstream accepts the byte this cycle
- o_last  output  1  high with o_valid on byte index N-1
- busy  output  1  high while a block is being emitted (state SEND)

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, counter=0, holding register all 8'h00.
  - Outputs during and after reset: o=8'h00, o_valid=0, o_last=0, busy=0, in_ready=1.
- Reset mid-block: the in-flight block is discarded; there is no partial resume.
- States:
  - IDLE: in_ready=1, o_valid=0. On in_valid=1 at a clock edge, capture i into the holding register, set counter=0, go to SEND.
  - SEND: o_valid=1, o=hold[counter], o_last=(counter==N-1).
    - o_ready=1 at an edge: byte accepted.
    - If counter<N-1: counter increments.
    - If counter==N-1 (last byte accepted): counter wraps to 0. If in_valid=1 in the same cycle, capture the new block and stay in SEND; otherwise go to IDLE.
    - o_ready=0: o, o_valid and o_last hold stable and counter holds. Stalls are unlimited.
- in_ready = (state==IDLE) || (state==SEND && counter==N-1 && o_ready). This is combinational from state, counter and o_ready.
- A block offered while busy (other than on the last-byte cycle) is not captured; the source must hold in_valid.
- Latency: block captured at edge t; byte 0 is valid in the cycle after t. With o_ready tied high, bytes 0..15 appear on consecutive cycles t+1..t+16.
- Back-to-back blocks with o_ready held high give 100% throughput: zero bubble cycles between byte 15 of one block and byte 0 of the next.
- o is driven directly from the holding register indexed by counter, with no extra pipeline stage.
  - In IDLE, o shows hold[0] of the last block (8'h00 after reset). It is don't-care unless o_valid=1.
- The holding register is written only on a capture. Input i is don't-care when no capture occurs.
- Counter never exceeds N-1, and o_last is never asserted unless o_valid=1.

Test Plan:
- Reset then idle: resetn low 3 cycles, release -> o_valid=0, o=8'h00, in_ready=1, busy=0. Same values when resetn is asserted asynchronously between clock edges.
- Single block: i=128'h0F0E0D0C0B0A09080706050403020100, in_valid for 1 cycle, o_ready=1 -> o sequence 00,01,...,0F on 16 consecutive cycles; o_last only on 0F; then IDLE, in_ready=1.
- Backpressure: same block, o_ready low for 3 cycles while o=8'h05 -> o holds 05 with o_valid=1 for the full stall; sequence resumes 06..0F with no byte lost or duplicated.
- Back-to-back: block A (bytes AA..) then block B=128'h{16{8'h5B}} presented with in_valid held -> B captured on A's last-byte cycle (in_ready=1 there only); first 5B appears the cycle after A's byte 15; no gap.
- Blocked load: in_valid=1 with a new block while emitting byte 3 -> in_ready=0; the current block continues unchanged and the new block is captured only at byte 15 acceptance.
- Reset mid-block: assert resetn=0 after byte 7 is output -> immediately o_valid=0, o=8'h00. After release, a fresh block starts at byte 0.

Source files
------------

// File: rtl/mod_reg16_16to1.sv
`default_nettype none
// ============================================================================
// Module   : mod_reg16_16to1
// Purpose  : Serializes one N-byte block into a valid/ready byte stream,
//            byte 0 first, with zero-bubble back-to-back block acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module mod_reg16_16to1 #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N-1:0][W-1:0] i,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [W-1:0]        o,
  output logic                o_valid,
  input  logic                o_ready,
  output logic                o_last,
  output logic                busy
);

  localparam int CW = $clog2(N);

  localparam logic [0:0]    c_IDLE = 1'b0;
  localparam logic [0:0]    c_SEND = 1'b1;
  localparam logic [CW-1:0] c_LAST = CW'(N - 1);

  logic [0:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [N-1:0][W-1:0] r_hold;

  logic w_last;
  logic w_capture;

  assign w_last    = (r_cnt == c_LAST);
  // A new block may land on the same edge the final byte leaves.
  assign in_ready  = (r_state == c_IDLE) || ((r_state == c_SEND) && w_last && o_ready);
  assign w_capture = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else if (w_capture) begin
      r_hold  <= i;
      r_cnt   <= '0;
      r_state <= c_SEND;
    end else if ((r_state == c_SEND) && o_ready) begin
      if (w_last) begin
        r_cnt   <= '0;
        r_state <= c_IDLE;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign o       = r_hold[r_cnt];
  assign o_valid = (r_state == c_SEND);
  assign o_last  = o_valid && w_last;
  assign busy    = o_valid;

endmodule
`default_nettype wire

// File: tb/tb_mod_reg16_16to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_reg16_16to1
// Purpose  : Self-checking bench for the block-to-byte serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_reg16_16to1;

  localparam int N = 16;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                resetn;
  logic [N-1:0][W-1:0] blk;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        o;
  logic                o_valid;
  logic                o_ready;
  logic                o_last;
  logic                busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_reg16_16to1 #(.N(N), .W(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i        (blk),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o        (o),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_last   (o_last),
    .busy     (busy)
  );

  // Reference: a queue of bytes still owed downstream.
  logic [7:0] q[$];
  bit         m_acc;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
    end else begin
      m_acc = in_valid && ((q.size() == 0) || (q.size() == 1 && o_ready));
      if (q.size() > 0 && o_ready) void'(q.pop_front());
      if (m_acc) for (int k = 0; k < N; k++) q.push_back(blk[k]);
    end
  end

  // {o_valid, o_last, busy, in_ready, o (masked when not valid)}
  logic [11:0] dut_vec;
  assign dut_vec = {o_valid, o_last, busy, in_ready, (o_valid ? o : 8'h00)};

  function automatic logic [11:0] model_vec();
    logic v;
    v = (q.size() != 0);
    return {v, (q.size() == 1), v, ((q.size() == 0) || (q.size() == 1 && o_ready)),
            (v ? q[0] : 8'h00)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0][W-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [11:0] obs;
    resetn = 1'b0; in_valid = 1'b0; o_ready = 1'b0; blk = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    obs = {o_valid, o_last, busy, in_ready, o};
    checks++;
    if (obs !== 12'h100) begin
      errors++; $display("FAIL reset_idle got %h exp %h", obs, 12'h100);
    end
    // Asynchronous assertion between edges while a block is loaded.
    blk = rand_blk(); blk[0] = 8'hC3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b0;
    #1 obs = {o_valid, o_last, busy, in_ready, o};
    checks++;
    if (obs !== 12'h100) begin
      errors++; $display("FAIL reset_async got %h exp %h", obs, 12'h100);
    end
    #1 resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_block();
    logic [11:0] exp;
    blk = 128'h0F0E0D0C0B0A09080706050403020100; in_valid = 1'b1; o_ready = 1'b1;
    tick();
    in_valid = 1'b0; blk = rand_blk();
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      exp = (c < 16) ? {1'b1, (c == 15), 1'b1, (c == 15), 8'(c)} : 12'h100;
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL single c=%0d got %h exp %h", c, dut_vec, exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp;
    int k, stall;
    blk = 128'h0F0E0D0C0B0A09080706050403020100; in_valid = 1'b1; o_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0; stall = 0;
    while (k < 16) begin
      o_ready = (k == 5 && stall < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp = {1'b1, (k == 15), 1'b1, (k == 15 && o_ready), 8'(k)};
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL backpressure k=%0d stall=%0d got %h exp %h", k, stall, dut_vec, exp);
      end
      if (o_ready) k++; else stall++;
      tick();
    end
    @(negedge clk);
    checks++;
    if (dut_vec !== 12'h100) begin
      errors++; $display("FAIL backpressure_end got %h exp %h", dut_vec, 12'h100);
    end
    tick();
  endtask

  // Second block offered while the first is in flight, from cycle first_c on.
  task automatic run_two_blocks(input string name, input logic [N-1:0][W-1:0] a,
                                input logic [N-1:0][W-1:0] b, input int first_c);
    logic [11:0] exp;
    logic [7:0]  eb;
    blk = a; in_valid = 1'b1; o_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 33; c++) begin
      if (c >= first_c && c <= 15) begin
        in_valid = 1'b1; blk = b;
      end else begin
        in_valid = 1'b0; blk = rand_blk();
      end
      @(negedge clk);
      eb  = (c < 16) ? a[c] : (c < 32) ? b[c-16] : 8'h00;
      exp = (c < 32) ? {1'b1, (c % 16 == 15), 1'b1, (c % 16 == 15), eb} : 12'h100;
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL %s c=%0d got %h exp %h", name, c, dut_vec, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0][W-1:0] a;
    for (int k = 0; k < N; k++) a[k] = 8'hA0 + 8'(k);
    run_two_blocks("back_to_back", a, {16{8'h5B}}, 0);
  endtask

  task automatic test_blocked_load();
    run_two_blocks("blocked_load", rand_blk(), rand_blk(), 3);
  endtask

  task automatic test_reset_mid_block();
    logic [N-1:0][W-1:0] e;
    logic [11:0] exp;
    logic [11:0] obs;
    e = rand_blk();
    blk = e; in_valid = 1'b1; o_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b1, 1'b0, e[c]};
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL mid_pre c=%0d got %h exp %h", c, dut_vec, exp);
      end
      if (c < 7) tick();
    end
    #2 resetn = 1'b0;
    #1 obs = {o_valid, o_last, busy, in_ready, o};
    checks++;
    if (obs !== 12'h100) begin
      errors++; $display("FAIL mid_reset got %h exp %h", obs, 12'h100);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL mid_reset_model got %h exp %h", dut_vec, model_vec());
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    e = rand_blk(); blk = e; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp = {1'b1, (c == 15), 1'b1, (c == 15), e[c]};
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL mid_fresh c=%0d got %h exp %h", c, dut_vec, exp);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      o_ready  = ($urandom_range(0, 3) != 0);
      blk      = rand_blk();
      @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL random n=%0d got %h exp %h", n, dut_vec, model_vec());
      end
      tick();
    end
    in_valid = 1'b0; o_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (dut_vec !== 12'h100) begin
      errors++; $display("FAIL random_drain got %h exp %h", dut_vec, 12'h100);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_back_to_back();
    test_blocked_load();
    test_reset_mid_block();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
